// File: rtl/match_filter_ctrl_if.sv
// Serial register bus carrying configuration writes into match_filter_ctrl.
//
// Handshake: serial_strobe is a one-cycle write qualifier. serial_addr and
// serial_data are valid only in a cycle where serial_strobe is high, and the
// write is taken on the rising clock edge that ends that cycle. There is no
// ready or back-pressure: the slave accepts every strobed write.
interface match_filter_ctrl_if;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;

    // Bus driver (register bus host).
    modport master (
        output serial_addr,
        output serial_data,
        output serial_strobe
    );

    // Bus receiver (the configuration sequencer).
    modport slave (
        input serial_addr,
        input serial_data,
        input serial_strobe
    );
endinterface

// File: rtl/match_filter_ctrl.sv
// Configuration sequencer and result monitor for the receive-path match filter.
// Collects eight shadow coefficient/control words from the serial bus, and on
// commit waits for a quiet gap in the sample stream before replaying them into
// the filter through cdata/cstate/cwrite while rxstrobe is gated off.
// Also keeps saturating counts of matches and of strobes dropped during loads.
module match_filter_ctrl #(
    parameter logic [6:0] BASE_ADDR = 7'd64,
    parameter int         HOLDOFF   = 8,
    parameter int         MAX_WAIT  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    match_filter_ctrl_if.slave  sbus,
    input  logic                rxstrobe_in,
    output logic                rxstrobe_out,
    output logic [31:0]         cdata,
    output logic [2:0]          cstate,
    output logic                cwrite,
    input  logic                mf_valid,
    input  logic                mf_match,
    output logic                busy,
    output logic                load_done,
    output logic [15:0]         match_count,
    output logic [15:0]         dropped_count,
    output logic [1:0]          state_dbg
);

    localparam int QW = $clog2(HOLDOFF + 1);
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_QUIET = 2'd1,
        ST_LOAD       = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     shadow_q [8];
    logic [31:0]     shadow_d [8];
    logic            enable_q, enable_d;
    logic            pending_q, pending_d;
    logic [QW-1:0]   quiet_cnt_q, quiet_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [2:0]      load_idx_q, load_idx_d;
    logic [31:0]     cdata_q, cdata_d;
    logic [2:0]      cstate_q, cstate_d;
    logic            cwrite_q, cwrite_d;
    logic [15:0]     match_count_q, match_count_d;
    logic [15:0]     dropped_count_q, dropped_count_d;

    logic [6:0]      addr_off;
    logic            shadow_wr;
    logic            ctrl_wr;
    logic            commit;
    logic            clear_cnt;
    logic            quiet_ok;
    logic            wait_expired;
    logic [2:0]      next_idx;

    // Decode the register bus: shadow words at offsets 0..7, control at 8.
    always_comb begin
        addr_off  = sbus.serial_addr - BASE_ADDR;
        shadow_wr = sbus.serial_strobe && (addr_off < 7'd8);
        ctrl_wr   = sbus.serial_strobe && (addr_off == 7'd8);
        commit    = ctrl_wr && sbus.serial_data[0];
        clear_cnt = ctrl_wr && sbus.serial_data[2];
    end

    // Shadow words and the latched enable bit; shadow writes land even mid-load.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        enable_d = enable_q;
        if (shadow_wr) begin
            shadow_d[addr_off[2:0]] = sbus.serial_data;
        end
        if (ctrl_wr) begin
            enable_d = sbus.serial_data[1];
        end
    end

    // Quiet-gap tracker. quiet_cnt_d counts strobe-free cycles up to and
    // including the current one; the load may start once the cycle after
    // this one would complete HOLDOFF strobe-free cycles since the last strobe,
    // so a strobe stream with period 2*HOLDOFF fits a full load between strobes.
    always_comb begin
        if (rxstrobe_in) begin
            quiet_cnt_d = '0;
        end else if (quiet_cnt_q == QW'(HOLDOFF)) begin
            quiet_cnt_d = quiet_cnt_q;
        end else begin
            quiet_cnt_d = quiet_cnt_q + QW'(1);
        end
        quiet_ok     = (quiet_cnt_d >= QW'(HOLDOFF - 1));
        wait_expired = (wait_cnt_q == WW'(MAX_WAIT - 1));
    end

    // Load sequencer: next state plus registered cdata/cstate/cwrite values.
    // Words go out as 1..7 then 0, so the control word in shadow[0] is applied last.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        wait_cnt_d = wait_cnt_q;
        load_idx_d = load_idx_q;
        cdata_d    = cdata_q;
        cstate_d   = 3'd0;
        cwrite_d   = 1'b0;
        next_idx   = load_idx_q + 3'd1;

        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                if (commit) begin
                    state_d = ST_WAIT_QUIET;
                end
            end
            ST_WAIT_QUIET: begin
                if (commit) begin
                    pending_d = 1'b1;
                end
                wait_cnt_d = wait_cnt_q + WW'(1);
                if (quiet_ok || wait_expired) begin
                    state_d    = ST_LOAD;
                    load_idx_d = 3'd1;
                    cwrite_d   = 1'b1;
                    cstate_d   = 3'd1;
                    cdata_d    = shadow_q[1];
                end
            end
            ST_LOAD: begin
                if (commit) begin
                    pending_d = 1'b1;
                end
                // load_idx_q is the word currently presented; word 0 is the last.
                if (load_idx_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    load_idx_d = next_idx;
                    cwrite_d   = 1'b1;
                    cstate_d   = next_idx;
                    cdata_d    = shadow_q[next_idx];
                end
            end
            ST_DONE: begin
                wait_cnt_d = '0;
                if (pending_q || commit) begin
                    pending_d = 1'b0;
                    state_d   = ST_WAIT_QUIET;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating match and dropped-strobe counters; clear beats increment.
    always_comb begin
        match_count_d   = match_count_q;
        dropped_count_d = dropped_count_q;
        if (clear_cnt) begin
            match_count_d   = '0;
            dropped_count_d = '0;
        end else begin
            if (enable_q && mf_valid && mf_match && (match_count_q != 16'hFFFF)) begin
                match_count_d = match_count_q + 16'd1;
            end
            if (enable_q && rxstrobe_in && (state_q == ST_LOAD) &&
                (dropped_count_q != 16'hFFFF)) begin
                dropped_count_d = dropped_count_q + 16'd1;
            end
        end
    end

    // State and datapath registers; reset aborts any load in progress at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= '0;
            end
            enable_q        <= 1'b0;
            pending_q       <= 1'b0;
            quiet_cnt_q     <= '0;
            wait_cnt_q      <= '0;
            load_idx_q      <= 3'd0;
            cdata_q         <= '0;
            cstate_q        <= 3'd0;
            cwrite_q        <= 1'b0;
            match_count_q   <= '0;
            dropped_count_q <= '0;
        end else begin
            state_q         <= state_d;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            enable_q        <= enable_d;
            pending_q       <= pending_d;
            quiet_cnt_q     <= quiet_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            load_idx_q      <= load_idx_d;
            cdata_q         <= cdata_d;
            cstate_q        <= cstate_d;
            cwrite_q        <= cwrite_d;
            match_count_q   <= match_count_d;
            dropped_count_q <= dropped_count_d;
        end
    end

    // Output mapping. busy drops in DONE unless another reload is queued.
    always_comb begin
        rxstrobe_out  = rxstrobe_in && enable_q && (state_q != ST_LOAD);
        cdata         = cdata_q;
        cstate        = cstate_q;
        cwrite        = cwrite_q;
        load_done     = (state_q == ST_DONE);
        busy          = (state_q == ST_WAIT_QUIET) || (state_q == ST_LOAD) ||
                        ((state_q == ST_DONE) && pending_q);
        match_count   = match_count_q;
        dropped_count = dropped_count_q;
        state_dbg     = state_q;
    end

endmodule
